// File: rtl/lsu_align.sv
// Load/store alignment unit: byte enables, lane shifting, load extension
// and two-beat splitting of accesses that cross a memory word.
module lsu_align #(
   parameter int XLEN             = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_type,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [2:0] {
      IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP
   } state_t;

   state_t            st;
   logic              r_we;
   logic [3:0]        r_sz;
   logic              r_sgn;
   logic [OW-1:0]     r_off;
   logic              r_split;
   logic [NB-1:0]     r_be1;
   logic [XLEN-1:0]   r_wd1;
   logic [XLEN-1:0]   stage;

   logic [3:0]        in_sz;
   logic              in_sgn;
   logic              in_bad;
   logic [OW-1:0]     in_off;
   logic [NB-1:0]     sz_mask;
   logic [2*NB-1:0]   be_full;
   logic [2*XLEN-1:0] wd_full;
   logic              in_split;
   logic              in_err;
   logic [XLEN-1:0]   base;
   logic [2*XLEN-1:0] rd_sh;
   logic [XLEN-1:0]   beat_data;

   always_comb begin
      in_sz  = 4'd0;
      in_sgn = 1'b0;
      in_bad = 1'b0;
      case (req_type)
         3'b000: begin in_sz = 4'd1; in_sgn = 1'b1; end
         3'b001: begin in_sz = 4'd2; in_sgn = 1'b1; end
         3'b010: begin in_sz = 4'd4; in_sgn = 1'b1; end
         3'b011: in_sz = 4'd1;
         3'b100: in_sz = 4'd2;
         3'b101: begin in_sz = 4'd8; in_bad = (XLEN == 32); end
         3'b110: begin in_sz = 4'd4; in_bad = (XLEN == 32); end
         default: in_bad = 1'b1;
      endcase
   end

   // Shifting into a double-width vector yields both beats at once:
   // the low half is beat 0, the high half spills into beat 1.
   assign in_off   = req_addr[OW-1:0];
   assign sz_mask  = ~({NB{1'b1}} << in_sz);
   assign be_full  = {{NB{1'b0}}, sz_mask} << in_off;
   assign wd_full  = {{XLEN{1'b0}}, (req_we ? req_wdata : '0)}
                     << {in_off, 3'b000};
   assign in_split = |be_full[2*NB-1:NB];
   assign in_err   = in_bad | (in_split & ~ALLOW_MISALIGNED);
   assign base     = {req_addr[XLEN-1:OW], {OW{1'b0}}};

   // Upper half: beat-0 bytes moved down to byte 0.
   // Lower half: beat-1 bytes moved up to byte NB-off.
   assign rd_sh     = {mem_rdata, {XLEN{1'b0}}} >> {r_off, 3'b000};
   assign beat_data = (st == WAIT1) ? (stage | rd_sh[XLEN-1:0])
                                    : rd_sh[2*XLEN-1:XLEN];

   function automatic logic [XLEN-1:0] ext(
      input logic [XLEN-1:0] d,
      input logic [3:0]      sz,
      input logic            sgn
   );
      logic [XLEN-1:0] m;
      logic            sb;
      m  = ~({XLEN{1'b1}} << {sz, 3'b000});
      sb = sgn & (|(d & (m ^ (m >> 1))));
      return (d & m) | (sb ? ~m : '0);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         req_ready <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         r_we      <= 1'b0;
         r_sz      <= '0;
         r_sgn     <= 1'b0;
         r_off     <= '0;
         r_split   <= 1'b0;
         r_be1     <= '0;
         r_wd1     <= '0;
         stage     <= '0;
      end else begin
         unique case (st)
            IDLE: if (req_valid && req_ready) begin
               req_ready <= 1'b0;
               r_we      <= req_we;
               r_sz      <= in_sz;
               r_sgn     <= in_sgn;
               r_off     <= in_off;
               r_split   <= in_split;
               r_be1     <= be_full[2*NB-1:NB];
               r_wd1     <= wd_full[2*XLEN-1:XLEN];
               stage     <= '0;
               if (in_err) begin
                  st        <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  st        <= ISSUE0;
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= base;
                  mem_be    <= be_full[NB-1:0];
                  mem_wdata <= wd_full[XLEN-1:0];
               end
            end
            ISSUE0, ISSUE1: if (mem_gnt) begin
               mem_req <= 1'b0;
               st      <= (st == ISSUE0) ? WAIT0 : WAIT1;
            end
            WAIT0, WAIT1: if (mem_rvalid) begin
               stage <= beat_data;
               if (st == WAIT0 && r_split) begin
                  st        <= ISSUE1;
                  mem_req   <= 1'b1;
                  mem_addr  <= mem_addr + XLEN'(NB);
                  mem_be    <= r_be1;
                  mem_wdata <= r_wd1;
               end else begin
                  st        <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= r_we ? '0 : ext(beat_data, r_sz, r_sgn);
               end
            end
            RESP: begin
               st        <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: XLEN=32 with and without misaligned
// splitting, plus an XLEN=64 instance.
module tb_lsu_align;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   int   t0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // instance a: XLEN=32, misaligned allowed
   logic        a_req_valid = 0, a_req_ready, a_req_we = 0;
   logic [2:0]  a_req_type = 0;
   logic [31:0] a_req_addr = 0, a_req_wdata = 0;
   logic        a_mem_req, a_mem_gnt = 0, a_mem_we;
   logic [31:0] a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        a_mem_rvalid = 0;
   logic [31:0] a_mem_rdata = 0;
   logic        a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata;

   // instance b: XLEN=32, misaligned rejected
   logic        b_req_valid = 0, b_req_ready, b_req_we = 0;
   logic [2:0]  b_req_type = 0;
   logic [31:0] b_req_addr = 0, b_req_wdata = 0;
   logic        b_mem_req, b_mem_gnt = 0, b_mem_we;
   logic [31:0] b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_be;
   logic        b_mem_rvalid = 0;
   logic [31:0] b_mem_rdata = 0;
   logic        b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata;
   logic        b_saw_req = 0;

   // instance c: XLEN=64
   logic        c_req_valid = 0, c_req_ready, c_req_we = 0;
   logic [2:0]  c_req_type = 0;
   logic [63:0] c_req_addr = 0, c_req_wdata = 0;
   logic        c_mem_req, c_mem_gnt = 0, c_mem_we;
   logic [63:0] c_mem_addr, c_mem_wdata;
   logic [7:0]  c_mem_be;
   logic        c_mem_rvalid = 0;
   logic [63:0] c_mem_rdata = 0;
   logic        c_rsp_valid, c_rsp_err;
   logic [63:0] c_rsp_rdata;

   lsu_align #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_we(a_req_we), .req_type(a_req_type),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .mem_req(a_mem_req), .mem_gnt(a_mem_gnt), .mem_we(a_mem_we),
      .mem_addr(a_mem_addr), .mem_be(a_mem_be),
      .mem_wdata(a_mem_wdata), .mem_rvalid(a_mem_rvalid),
      .mem_rdata(a_mem_rdata), .rsp_valid(a_rsp_valid),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   lsu_align #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_type(b_req_type),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .mem_req(b_mem_req), .mem_gnt(b_mem_gnt), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid),
      .mem_rdata(b_mem_rdata), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   lsu_align #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_c (
      .clk(clk), .rst(rst),
      .req_valid(c_req_valid), .req_ready(c_req_ready),
      .req_we(c_req_we), .req_type(c_req_type),
      .req_addr(c_req_addr), .req_wdata(c_req_wdata),
      .mem_req(c_mem_req), .mem_gnt(c_mem_gnt), .mem_we(c_mem_we),
      .mem_addr(c_mem_addr), .mem_be(c_mem_be),
      .mem_wdata(c_mem_wdata), .mem_rvalid(c_mem_rvalid),
      .mem_rdata(c_mem_rdata), .rsp_valid(c_rsp_valid),
      .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err)
   );

   always @(posedge clk) if (b_mem_req) b_saw_req <= 1'b1;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic a_send(input logic we, input logic [2:0] ty,
                         input logic [31:0] addr, input logic [31:0] wd);
      a_req_valid = 1'b1;
      a_req_we    = we;
      a_req_type  = ty;
      a_req_addr  = addr;
      a_req_wdata = wd;
      t0 = cyc;
      @(negedge clk);
      a_req_valid = 1'b0;
   endtask

   task automatic a_beat(input string tag, input logic we,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int gdly,
                         input logic [31:0] rd);
      check({tag, " beat"},
            {a_mem_req, a_mem_we, a_mem_addr, a_mem_be, a_mem_wdata},
            {1'b1, we, addr, be, wd});
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk);
         check({tag, " hold"},
               {a_mem_req, a_mem_we, a_mem_addr, a_mem_be, a_mem_wdata},
               {1'b1, we, addr, be, wd});
      end
      a_mem_gnt = 1'b1;
      @(negedge clk);
      a_mem_gnt = 1'b0;
      check({tag, " req drop"}, a_mem_req, 1'b0);
      a_mem_rvalid = 1'b1;
      a_mem_rdata  = rd;
      @(negedge clk);
      a_mem_rvalid = 1'b0;
      a_mem_rdata  = '0;
   endtask

   task automatic a_rsp(input string tag, input logic [31:0] rd,
                        input logic err, input int lat);
      int k = 0;
      while (!a_rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, " rsp_valid"}, a_rsp_valid, 1'b1);
      check({tag, " latency"}, cyc - t0, lat);
      check({tag, " rsp"}, {a_rsp_err, a_rsp_rdata}, {err, rd});
      @(negedge clk);
      check({tag, " pulse"}, {a_rsp_valid, a_req_ready}, 2'b01);
   endtask

   task automatic b_err(input string tag, input logic [2:0] ty,
                        input logic [31:0] addr);
      b_req_valid = 1'b1;
      b_req_type  = ty;
      b_req_addr  = addr;
      @(negedge clk);
      b_req_valid = 1'b0;
      check({tag, " rsp"}, {b_rsp_valid, b_rsp_err, b_rsp_rdata},
            {1'b1, 1'b1, 32'h0});
      @(negedge clk);
      check({tag, " pulse"}, {b_rsp_valid, b_req_ready}, 2'b01);
   endtask

   task automatic c_run(input string tag, input logic [2:0] ty,
                        input logic [63:0] addr, input logic [63:0] maddr,
                        input logic [7:0] be, input logic [63:0] rd,
                        input logic [63:0] exp);
      c_req_valid = 1'b1;
      c_req_type  = ty;
      c_req_addr  = addr;
      @(negedge clk);
      c_req_valid = 1'b0;
      check({tag, " beat"}, {c_mem_req, c_mem_addr, c_mem_be},
            {1'b1, maddr, be});
      c_mem_gnt = 1'b1;
      @(negedge clk);
      c_mem_gnt    = 1'b0;
      c_mem_rvalid = 1'b1;
      c_mem_rdata  = rd;
      @(negedge clk);
      c_mem_rvalid = 1'b0;
      check({tag, " rsp"}, {c_rsp_valid, c_rsp_err, c_rsp_rdata},
            {1'b1, 1'b0, exp});
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset outputs",
            {a_req_ready, a_mem_req, a_mem_we, a_mem_addr, a_mem_be,
             a_mem_wdata, a_rsp_valid, a_rsp_rdata, a_rsp_err},
            {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0});

      a_send(0, 3'b011, 32'h102, 32'h0);
      a_beat("lbu", 0, 32'h100, 4'b0100, 32'h0, 0, 32'h12345678);
      a_rsp("lbu", 32'h34, 0, 3);

      a_send(0, 3'b000, 32'h102, 32'h0);
      a_beat("lb", 0, 32'h100, 4'b0100, 32'h0, 0, 32'h00ff0000);
      a_rsp("lb", 32'hffffffff, 0, 3);

      a_send(0, 3'b100, 32'h102, 32'h0);
      a_beat("lhu", 0, 32'h100, 4'b1100, 32'h0, 0, 32'h12345678);
      a_rsp("lhu", 32'h1234, 0, 3);

      a_send(0, 3'b010, 32'h100, 32'h0);
      a_beat("lw", 0, 32'h100, 4'b1111, 32'h0, 0, 32'h12345678);
      a_rsp("lw", 32'h12345678, 0, 3);

      a_send(1, 3'b001, 32'h106, 32'h0000abcd);
      a_beat("sh", 1, 32'h104, 4'b1100, 32'habcd0000, 3, 32'h0);
      a_rsp("sh", 32'h0, 0, 6);

      a_send(0, 3'b010, 32'h103, 32'h0);
      a_beat("mlw b0", 0, 32'h100, 4'b1000, 32'h0, 0, 32'h11223344);
      a_beat("mlw b1", 0, 32'h104, 4'b0111, 32'h0, 0, 32'h55667788);
      a_rsp("mlw", 32'h66778811, 0, 5);

      a_send(0, 3'b001, 32'h107, 32'h0);
      a_beat("mlh b0", 0, 32'h104, 4'b1000, 32'h0, 0, 32'hfe000000);
      a_beat("mlh b1", 0, 32'h108, 4'b0001, 32'h0, 0, 32'h000000ff);
      a_rsp("mlh", 32'hfffffffe, 0, 5);

      a_send(1, 3'b010, 32'hfffffffe, 32'haabbccdd);
      a_beat("wrap b0", 1, 32'hfffffffc, 4'b1100, 32'hccdd0000, 1, 0);
      a_beat("wrap b1", 1, 32'h00000000, 4'b0011, 32'h0000aabb, 0, 0);
      a_rsp("wrap", 32'h0, 0, 6);

      a_send(0, 3'b101, 32'h100, 32'h0);
      check("ld32 no mem", a_mem_req, 1'b0);
      a_rsp("ld32", 32'h0, 1, 1);

      a_send(0, 3'b111, 32'h100, 32'h0);
      check("t111 no mem", a_mem_req, 1'b0);
      a_rsp("t111", 32'h0, 1, 1);

      b_err("nomis lh", 3'b001, 32'h103);
      b_err("nomis lw", 3'b010, 32'h102);
      b_err("nomis t101", 3'b101, 32'h100);
      check("nomis no mem_req", b_saw_req, 1'b0);

      a_send(0, 3'b010, 32'h200, 32'h0);
      a_mem_gnt = 1'b1;
      @(negedge clk);
      a_mem_gnt = 1'b0;
      check("rst wait0", a_mem_req, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_mem_rvalid = 1'b1;
      a_mem_rdata  = 32'hdeadbeef;
      check("rst abort outputs",
            {a_req_ready, a_mem_req, a_mem_we, a_mem_addr, a_mem_be,
             a_mem_wdata, a_rsp_valid, a_rsp_rdata, a_rsp_err},
            {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0});
      @(negedge clk);
      a_mem_rvalid = 1'b0;
      a_mem_rdata  = '0;
      for (int i = 0; i < 3; i++) begin
         check("rst stray rvalid", {a_req_ready, a_rsp_valid, a_mem_req},
               3'b100);
         @(negedge clk);
      end

      a_send(0, 3'b010, 32'h100, 32'h0);
      a_beat("post rst", 0, 32'h100, 4'b1111, 32'h0, 0, 32'hcafef00d);
      a_rsp("post rst", 32'hcafef00d, 0, 3);

      c_run("lwu64", 3'b110, 64'h1004, 64'h1000, 8'hf0,
            64'h80000001_00000000, 64'h00000000_80000001);
      c_run("lw64", 3'b010, 64'h1004, 64'h1000, 8'hf0,
            64'h80000001_00000000, 64'hffffffff_80000001);
      c_run("ld64", 3'b101, 64'h2000, 64'h2000, 8'hff,
            64'h80000001_00000000, 64'h80000001_00000000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
